// File: rtl/ball_control_pkg.sv
// Shared game types, screen constants and the ball
// flight interpolation helper.
package ball_control_pkg;

  typedef enum logic [1:0] {
    MENU        = 2'd0,
    SOLO_KEEPER = 2'd1,
    MULTI       = 2'd2,
    GAME_OVER   = 2'd3
  } g_state;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
  localparam int CNT_W =
    $clog2(HOR_PIXELS > VER_PIXELS ?
           HOR_PIXELS : VER_PIXELS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    AIM,
    FLIGHT,
    DONE
  } ball_state_t;

  // st + ((tg - st) * step) >>> sh, signed 13-bit
  // difference and 19-bit product.
  function automatic logic [11:0] lerp(
    input logic [11:0] st,
    input logic [11:0] tg,
    input logic [5:0]  step,
    input int          sh
  );
    logic signed [12:0] d;
    logic signed [18:0] p;
    d = $signed({1'b0, tg}) - $signed({1'b0, st});
    p = $signed({{6{d[12]}}, d}) *
        $signed({13'b0, step});
    return 12'($signed({7'b0, st}) + (p >>> sh));
  endfunction

endpackage

// File: rtl/ball_control_if.sv
// VGA timing/pixel stream bundle; master drives,
// slave consumes.
interface ball_control_if;
  import ball_control_pkg::*;

  logic [CNT_W-1:0] hcount;
  logic             hsync;
  logic             hblnk;
  logic [CNT_W-1:0] vcount;
  logic             vsync;
  logic             vblnk;
  logic [11:0]      rgb;

  modport master (
    output hcount, hsync, hblnk,
    output vcount, vsync, vblnk, rgb
  );

  modport slave (
    input hcount, hsync, hblnk,
    input vcount, vsync, vblnk, rgb
  );
endinterface

// File: rtl/ball_control_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free running;
// a non-zero seed keeps it out of the lock-up state.
module ball_control_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);
  localparam logic [15:0] TAPS = 16'hB400;

  // shift right, fold the dropped bit into the taps
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= SEED;
    else
      lfsr <= {1'b0, lfsr[15:1]} ^
              (lfsr[0] ? TAPS : 16'h0000);
  end
endmodule

// File: rtl/ball_control.sv
// Solo shooter: picks a random goal target per round
// and flies the ball there, overlaid on the VGA stream.
module ball_control
  import ball_control_pkg::*;
#(
  parameter int          BALL_SIZE   = 16,
  parameter logic [11:0] BALL_COLOR  = 12'hFFF,
  parameter int          START_X     = 504,
  parameter int          START_Y     = 640,
  parameter int          GOAL_X0     = 256,
  parameter int          GOAL_Y0     = 160,
  parameter int          AIM_FRAMES  = 30,
  parameter int          FLIGHT_LOG2 = 5,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  g_state         game_state,
  input  logic           round_start,
  ball_control_if.slave  in,
  ball_control_if.master out,
  output logic [11:0]    shot_xpos,
  output logic [11:0]    shot_ypos,
  output logic           shot_valid,
  output logic           ball_arrived
);
  localparam logic [11:0] SX  = 12'(START_X);
  localparam logic [11:0] SY  = 12'(START_Y);
  localparam logic [11:0] GX0 = 12'(GOAL_X0);
  localparam logic [11:0] GY0 = 12'(GOAL_Y0);
  localparam logic [11:0] BSZ = 12'(BALL_SIZE);
  localparam int SW = FLIGHT_LOG2 + 1;
  localparam logic [SW-1:0] STEP_MAX =
    SW'(1 << FLIGHT_LOG2);
  localparam logic [7:0] AIM_LAST =
    8'(AIM_FRAMES - 1);

  ball_state_t   state;
  logic [15:0]   lfsr;
  logic [7:0]    frame_cnt;
  logic [SW-1:0] step;
  logic [SW-1:0] step_nx;
  logic [11:0]   bx;
  logic [11:0]   by;
  logic [11:0]   hx;
  logic [11:0]   vy;
  logic          tick;
  logic          solo;
  logic          hit;

  ball_control_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign tick    = in.vcount == '0 &&
                   in.hcount == '0;
  assign solo    = game_state == SOLO_KEEPER;
  assign step_nx = step + SW'(1);
  assign hx      = 12'(in.hcount);
  assign vy      = 12'(in.vcount);

  assign hit = state != IDLE &&
               !in.hblnk && !in.vblnk &&
               hx >= bx && hx < bx + BSZ &&
               vy >= by && vy < by + BSZ;

  // round FSM: aim countdown, per-frame flight steps
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      step         <= '0;
      bx           <= '0;
      by           <= '0;
      shot_xpos    <= '0;
      shot_ypos    <= '0;
      shot_valid   <= 1'b0;
      ball_arrived <= 1'b0;
    end else begin
      ball_arrived <= 1'b0;
      if (!solo) begin
        state      <= IDLE;
        shot_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (round_start) begin
              state      <= AIM;
              shot_xpos  <= GX0 + {3'b0, lfsr[8:0]};
              shot_ypos  <= GY0 + {5'b0, lfsr[15:9]};
              shot_valid <= 1'b1;
              frame_cnt  <= '0;
              step       <= '0;
              bx         <= SX;
              by         <= SY;
            end
          end
          AIM: begin
            if (tick) begin
              if (frame_cnt == AIM_LAST) begin
                state <= FLIGHT;
                step  <= '0;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          FLIGHT: begin
            if (tick) begin
              step <= step_nx;
              bx   <= lerp(SX, shot_xpos,
                           6'(step_nx), FLIGHT_LOG2);
              by   <= lerp(SY, shot_ypos,
                           6'(step_nx), FLIGHT_LOG2);
              if (step_nx == STEP_MAX) begin
                state        <= DONE;
                ball_arrived <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // one-cycle pipelined pass-through with ball overlay
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= in.hcount;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.vcount <= in.vcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.rgb    <= hit ? BALL_COLOR : in.rgb;
    end
  end
endmodule
